// File: rtl/mul_div_unit_if.sv
// Request/response bundle between execute-stage control and the iterative RV32M mul/div unit.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Handshake: start is sampled only while busy is low (a start while busy is dropped);
    // done pulses for one cycle with result valid, and result then holds until the next accepted start.
    modport master (output start, funct3, rs1, rs2, flush, input busy, done, result);
    modport slave  (input start, funct3, rs1, rs2, flush, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_ZERO_BYPASS_EN sends zero-operand multiplies/divides down the one-cycle fast path.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  bus,
    output logic [1:0]     dbg_state_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              is_div, signed_a, signed_b, neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              fast;
    logic [XLEN-1:0]   fast_val;
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, fix_val;

    assign accept = (state_q == S_IDLE) && bus.start && !bus.flush;

    // Request decode: operand signedness, magnitudes and the divide special cases.
    always_comb begin
        is_div   = bus.funct3[2];
        signed_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        signed_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        neg_a    = signed_a && bus.rs1[XLEN-1];
        neg_b    = signed_b && bus.rs2[XLEN-1];
        abs_a    = neg_a ? -bus.rs1 : bus.rs1;
        abs_b    = neg_b ? -bus.rs2 : bus.rs2;
        fast     = 1'b0;
        fast_val = '0;
        if (is_div && (bus.rs2 == '0)) begin
            fast     = 1'b1;
            fast_val = bus.funct3[1] ? bus.rs1 : '1;
        end else if (is_div && !bus.funct3[0] && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.rs2 == '1)) begin
            fast     = 1'b1;
            fast_val = bus.funct3[1] ? '0 : bus.rs1;
        end
`ifdef MULDIV_ZERO_BYPASS_EN
        else if (!is_div && ((bus.rs1 == '0) || (bus.rs2 == '0))) begin
            fast = 1'b1;
        end else if (is_div && (bus.rs1 == '0)) begin
            fast = 1'b1;
        end
`else
`endif
    end

    // One iteration: acc holds {hi, lo} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge   = rem_sh >= {1'b0, opnd_q};
        rem_diff = div_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
        if (op_q[2]) begin
            acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quot;
            default:                fix_val = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = fast ? S_DONE : S_CALC;
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(XLEN-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            op_q    <= bus.funct3;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            opnd_q  <= is_div ? abs_b : abs_a;
            acc_q   <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
            if (fast) begin
                result_q <= fast_val;
            end
        end else if ((state_q == S_CALC) && !bus.flush) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
        end else if (state_q == S_FIX) begin
            result_q <= fix_val;
        end
    end

    // The FIX cycle presents the freshly corrected value so result is valid alongside done.
    always_comb begin
        bus.busy    = (state_q != S_IDLE);
        bus.done    = (state_q == S_FIX) || (state_q == S_DONE);
        bus.result  = (state_q == S_FIX) ? fix_val : result_q;
        dbg_state_o = state_q;
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: driver pushes expected result/done-cycle, a monitor checks on done.
module tb_mul_div_unit;
    localparam int W = 32;
`ifdef MULDIV_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         cyc;
    int         n_tests;
    int         n_fail;
    logic       prev_done;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    mul_div_unit_if #(.XLEN(W)) bus ();

    mul_div_unit #(.XLEN(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic start_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp, input int lat, input bit push);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (push) begin
            exp_q.push_back(exp);
            exp_cyc_q.push_back(cyc + lat - 1);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int low_cnt;
        low_cnt = 0;
        start_op(f3, a, b, exp, lat, 1'b1);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (!bus.busy) low_cnt++;
        end
        check({name, "_busy_window"}, low_cnt, 0);
        @(negedge clk);
        check({name, "_busy_after"}, {31'd0, bus.busy}, 0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check({name, "_idle"}, {31'd0, bus.busy}, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            check("done_gap", {31'd0, prev_done}, 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h at cycle %0d expected no done", bus.result, cyc);
            end else begin
                check("result", bus.result, exp_q.pop_front());
                check("done_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
        prev_done = bus.done;
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        prev_done  = 1'b0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.rs1    = '0;
        bus.rs2    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_result", bus.result, 0);
        check("rst_state", {30'd0, dbg_state}, 0);
        rst_n = 1'b1;

        run_op("mul_neg",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mul_big",      3'b000, 32'h12345678, 32'h10,       32'h23456780, 33);
        run_op("mulhu",        3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu",       3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("mulh_min",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("mulh_m1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("div_neg",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem_neg",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("div_negdiv",   3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("rem_negdiv",   3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
        run_op("divu",         3'b101, 32'd100,      32'd7,        32'd14,       33);
        run_op("remu",         3'b111, 32'd100,      32'd7,        32'd2,        33);
        run_op("remu_wide",    3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33);
        run_op("divu_by1",     3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33);
        run_op("divu_zero",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_zero",     3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_op("mul_zero",     3'b000, 32'd0,        32'h1234,     32'd0,        ZLAT);
        run_op("divu_zero_dd", 3'b101, 32'd0,        32'd5,        32'd0,        ZLAT);

        // start while busy must be dropped
        start_op(3'b000, 32'h1234, 32'h10, 32'h12340, 33, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.rs1    = 32'd3;
        bus.rs2    = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle("ignored_start");
        repeat (3) @(negedge clk);

        // flush mid-flight: no done, result keeps previous value
        start_op(3'b000, 32'd5, 32'd6, 32'd30, 33, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 0);
        check("flush_result", bus.result, 32'h12340);
        repeat (40) @(negedge clk);
        check("flush_result_later", bus.result, 32'h12340);

        // start together with flush in IDLE is dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush_busy", {31'd0, bus.busy}, 0);

        // asynchronous reset mid-flight
        start_op(3'b000, 32'd9, 32'd9, 32'd81, 33, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_done", {31'd0, bus.done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit; executes the eight funct7=0000001 OP instructions that the single-cycle ALU does not cover.
- Sits beside the ALU in the execute stage. Control issues one operation with a start pulse and stalls on busy until done.
- Shift-add multiply and restoring divide, one bit per cycle, with dedicated fast paths for divide special cases.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; accepted only in IDLE
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  XLEN  operand A (multiplicand / dividend)
- rs2  input  XLEN  operand B (multiplier / divisor)
- flush  input  1  abort the in-flight operation (pipeline kill)
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  result, held from done until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset asserted mid-operation discards the operation and produces no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 accepts the request at edge T. Latch funct3, operand signs, absolute values per signedness, and iteration counter=0.
  - DIV/REM with rs2==0, or signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): go directly to DONE; done=1 in cycle T+1.
  - All other requests: go to CALC.
- CALC: one iteration per cycle for XLEN cycles (T+1..T+32). The counter increments each cycle and leaves CALC when it reaches XLEN-1.
  - Multiply: 64-bit accumulator.
  - Divide: restoring shift/subtract on 64-bit remainder:quotient.
- FIX (T+33): apply signs, select the output, and register result. done=1 in T+33. The next state is IDLE (DONE is used only by the fast path). busy=1 from T+1 through the cycle done is high.
- Signedness:
  - MUL: low 32 bits.
  - MULH: signed×signed high.
  - MULHSU: signed rs1 × unsigned rs2, high.
  - MULHU: unsigned high.
  - DIV/REM: quotient rounds toward zero; remainder takes the sign of the dividend.
- Special cases (spec-mandated):
  - x/0: quotient 0xFFFFFFFF (DIV and DIVU); remainder = rs1.
  - Overflow: DIV = 0x80000000, REM = 0.
- start while busy=1 is ignored; no queueing.
- flush: the state returns to IDLE on the next edge, no done is produced, and result keeps its previous value. A flush coinciding with the done cycle does not suppress that done. flush in IDLE has no effect. When start and flush are both asserted in IDLE, flush wins and the request is dropped.
- done never asserts in two consecutive cycles.

Optional Feature:
- Macro: MULDIV_ZERO_BYPASS_EN.
- Defined: a multiply with rs1==0 or rs2==0, or a DIV/DIVU/REM/REMU with rs1==0 and rs2!=0, takes the fast path. Result is 0 with done at T+1.
- Undefined: these operations run the full XLEN iterations with done at T+33. Results are identical either way; only latency differs.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result=0xFFFFFFEB, done exactly at T+33, busy high T+1..T+33.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULH 0x80000000×0x80000000 -> 0x40000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done at T+1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, done at T+1.
- Checks on one in-flight MUL:
  - start at T+5 with new operands is ignored, and the original result is returned.
  - flush at T+10 -> no done, busy=0 at T+11, result unchanged.
  - rst_n low at T+12 -> result=0, busy=0 immediately.
- With MULDIV_ZERO_BYPASS_EN: MUL 0×0x1234 -> 0 with done at T+1; without the macro, same result at T+33.
